lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit directly downstream of the execute-stage ALU. It consumes the ALU result as the effective address and rs2 as store data. It runs a request/acknowledge transaction on the data-memory port, with byte-enable generation and misalignment detection, and formats load data for writeback. While a memory access is outstanding it stalls the pipeline.

Parameters:
BUS_TIMEOUT, 0, cycles allowed in ACCESS without dm_ack before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  EX-stage instruction valid
ex_load  in  1  instruction is a load
ex_store  in  1  instruction is a store
ex_funct3  in  3  RV32I funct3 of the load/store
ex_addr  in  32  effective address (ALU result)
ex_store_data  in  32  rs2 value
ex_rd  in  5  load destination register
lsu_stall  out  1  hold the pipeline (combinational)
dm_req  out  1  memory request
dm_we  out  1  1 = write, 0 = read
dm_be  out  4  byte enables
dm_addr  out  32  word address, bits [1:0] forced to 0
dm_wdata  out  32  lane-aligned store data
dm_rdata  in  32  read data, valid with dm_ack
dm_ack  in  1  memory completion
wb_valid  out  1  load result valid (one-cycle pulse)
wb_rd  out  5  load destination
wb_data  out  32  sign- or zero-extended load data
misalign  out  1  one-cycle pulse: misaligned access dropped
misalign_addr  out  32  address of the last misaligned access
bus_err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset values: FSM = IDLE. dm_req, dm_we, dm_be, dm_addr, dm_wdata, wb_valid, wb_rd, wb_data, misalign, misalign_addr, bus_err are all 0. The timeout counter is 0.
- Reset asserted mid-ACCESS: return to IDLE with dm_req = 0 on the next cycle. No wb_valid is produced; the memory must tolerate the abandoned request.
- FSM states: IDLE, ACCESS, DONE.
- Memory op: op = ex_valid & (ex_load ^ ex_store).
- Legal funct3, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3, stores: 000 SB, 001 SH, 010 SW.
- Any other funct3, or ex_load & ex_store both set: the op is ignored. No access, no stall, no flags.
- Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- IDLE, op legal and misaligned:
  - Stay in IDLE, lsu_stall = 0.
  - misalign = 1 next cycle; misalign_addr <= ex_addr.
  - No memory access and no writeback.
- IDLE, op legal and aligned, on the same edge:
  - Latch dm_addr = {ex_addr[31:2], 2'b00}, dm_we = ex_store, ex_rd, funct3 and offset = ex_addr[1:0].
  - dm_be: byte = 0001 << off; half = 0011 << off; word = 1111. Loads also drive these enables.
  - dm_wdata = ex_store_data << (8 * off).
  - Go to ACCESS.
- lsu_stall is 1 when (state == IDLE & op legal & aligned) or state == ACCESS. It is 0 otherwise, including in DONE.
- ACCESS:
  - dm_req = 1, all dm_* outputs held stable.
  - dm_ack is sampled every cycle, including the first.
  - On dm_ack, go to DONE. For a load, capture the formatted data:
    - rdata is shifted right by 8 * off.
    - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- DONE (one cycle):
  - dm_req = 0, lsu_stall = 0, so the pipeline advances.
  - For a load, wb_valid = 1 with wb_rd and wb_data. wb_rd = 0 is still reported; the register file ignores it.
  - Stores produce no wb_valid.
  - ex_* inputs are ignored in DONE, since they still show the completed instruction.
  - Next state is IDLE.
- Minimum latency: accept in cycle 0, ACCESS with ack in cycle 1, DONE/writeback in cycle 2.
- dm_ack outside ACCESS is ignored.
- Timeout (BUS_TIMEOUT > 0):
  - The counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When the counter == BUS_TIMEOUT - 1 and there is no ack, go to DONE with bus_err = 1 in DONE and wb_valid = 0.
  - An ack arriving in the same cycle as the timeout wins.
- The 32-bit shifts drop the overflow bits; dm_addr never increments or wraps.

Test Plan:
- LW at 0x100: dm_ack in first ACCESS cycle with rdata 0xDEADBEEF -> lsu_stall high for 2 cycles; wb_valid in cycle 2 with wb_data 0xDEADBEEF and wb_rd as driven.
- LB / LBU at 0x103, rdata 0x80FF_0000 -> wb_data 0xFFFFFF80 / 0x00000080.
- SB at 0x102, rs2 0x000000AB -> dm_be 0100, dm_wdata 0x00AB0000, dm_we 1, no wb_valid.
- SH at 0x202, rs2 0x1234 -> dm_be 1100, dm_wdata 0x12340000.
- LW at 0x101 -> no dm_req, lsu_stall 0, misalign pulse, misalign_addr 0x101.
- BUS_TIMEOUT = 4, no ack -> 4 ACCESS cycles, then DONE with bus_err = 1.
- Separately, rst during ACCESS -> dm_req 0 next cycle and no writeback.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit: drives a req/ack data-memory transaction for EX-stage loads and stores,
// generates byte lanes, drops misaligned accesses and formats load data for writeback.
module lsu_ctrl #(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    output logic        lsu_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic [31:0] misalign_addr,
    output logic        bus_err
);

    localparam int unsigned CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam bit TO_EN = (BUS_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              is_op;
    logic              legal_f3;
    logic              misaligned;
    logic              accept;
    logic              mis_hit;
    logic              timeout;
    logic [3:0]        be_c;
    logic [31:0]       rdata_sh;
    logic [31:0]       load_fmt;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [4:0]        rd_q;
    logic [CNT_W-1:0]  to_cnt;

    // Instruction decode: legality, alignment and lane enables
    always_comb begin
        is_op      = ex_valid & (ex_load ^ ex_store);
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        be_c       = 4'b1111;
        if (ex_load) begin
            case (ex_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
                default:                                legal_f3 = 1'b0;
            endcase
        end else begin
            case (ex_funct3)
                3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
                default:                legal_f3 = 1'b0;
            endcase
        end
        case (ex_funct3[1:0])
            2'b00: begin
                misaligned = 1'b0;
                be_c       = 4'b0001 << ex_addr[1:0];
            end
            2'b01: begin
                misaligned = ex_addr[0];
                be_c       = 4'b0011 << ex_addr[1:0];
            end
            default: begin
                misaligned = |ex_addr[1:0];
                be_c       = 4'b1111;
            end
        endcase
    end

    assign accept  = (state == IDLE) & is_op & legal_f3 & ~misaligned;
    assign mis_hit = (state == IDLE) & is_op & legal_f3 & misaligned;

    // Load data alignment and extension
    always_comb begin
        rdata_sh = dm_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  load_fmt = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  load_fmt = {24'd0, rdata_sh[7:0]};
            3'b101:  load_fmt = {16'd0, rdata_sh[15:0]};
            default: load_fmt = rdata_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, stall and timeout decision; an ack beats a same-cycle timeout
    always_comb begin
        state_d   = state;
        lsu_stall = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d   = ACCESS;
                    lsu_stall = 1'b1;
                end
            end
            ACCESS: begin
                lsu_stall = 1'b1;
                if (dm_ack) begin
                    state_d = DONE;
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    state_d = DONE;
                    timeout = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_be         <= 4'd0;
            dm_addr       <= 32'd0;
            dm_wdata      <= 32'd0;
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'd0;
            misalign      <= 1'b0;
            misalign_addr <= 32'd0;
            bus_err       <= 1'b0;
            funct3_q      <= 3'd0;
            off_q         <= 2'd0;
            rd_q          <= 5'd0;
            to_cnt        <= '0;
        end else begin
            dm_req   <= (state_d == ACCESS);
            misalign <= mis_hit;
            bus_err  <= timeout;
            wb_valid <= (state == ACCESS) & dm_ack & ~dm_we;
            if (mis_hit) begin
                misalign_addr <= ex_addr;
            end
            if (accept) begin
                dm_addr  <= {ex_addr[31:2], 2'b00};
                dm_we    <= ex_store;
                dm_be    <= be_c;
                dm_wdata <= ex_store_data << {ex_addr[1:0], 3'b000};
                funct3_q <= ex_funct3;
                off_q    <= ex_addr[1:0];
                rd_q     <= ex_rd;
                to_cnt   <= '0;
            end else if ((state == ACCESS) && !dm_ack) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
            if ((state == ACCESS) && dm_ack && !dm_we) begin
                wb_rd   <= rd_q;
                wb_data <= load_fmt;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized scoreboard bench for lsu_ctrl: a byte-level model predicts memory, writeback,
// misalign and bus-error events; a monitor pops and compares them as the DUT presents them.
module tb_lsu_ctrl;

    localparam int unsigned BUS_TO = 4;
    localparam int K_MEM = 0;
    localparam int K_WB  = 1;
    localparam int K_MIS = 2;
    localparam int K_ERR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_load = 1'b0;
    logic        ex_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_store_data = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        lsu_stall;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata = 32'd0;
    logic        dm_ack = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic        bus_err;

    lsu_ctrl #(.BUS_TIMEOUT(BUS_TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .lsu_stall(lsu_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .misalign_addr(misalign_addr), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic        we;
        logic [3:0]  be;
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        int          delay;
        bit          noack;
        logic [31:0] rdata;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int kind, input logic we, input logic [3:0] be,
                                input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        exp_t e;
        e.kind = kind; e.we = we; e.be = be; e.a = a; e.d = d; e.rd = rd;
        return e;
    endfunction

    // Reference model: byte lanes as plain byte arithmetic
    function automatic logic [3:0] m_be(input int off, input int sz);
        logic [3:0] b = 4'd0;
        for (int k = 0; k < 4; k++) if (k >= off && k < off + sz) b[k] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] sd, input int off);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < 4; k++) if (k >= off) w[8*k +: 8] = sd[8*(k-off) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input int off, input int sz,
                                           input bit uns);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!uns && sz < 4 && v[8*sz-1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Memory responder: acks after the requested delay; random acks while idle must be ignored
    bit busy = 1'b0;
    int wait_n = 0;
    rsp_t cur_rsp;
    always @(negedge clk) begin
        if (dm_req === 1'b1) begin
            if (!busy) begin
                busy = 1'b1;
                if (rsp_q.size() > 0) cur_rsp = rsp_q.pop_front();
                else begin cur_rsp.delay = 0; cur_rsp.noack = 1'b0; cur_rsp.rdata = 32'd0; end
                wait_n = cur_rsp.delay;
            end
            dm_ack   = (wait_n == 0) && !cur_rsp.noack;
            dm_rdata = cur_rsp.rdata;
            if (wait_n > 0) wait_n--;
        end else begin
            busy     = 1'b0;
            dm_ack   = ($urandom_range(0, 3) == 0);
            dm_rdata = $urandom;
        end
    end

    // Monitor: pops expected events in order as the DUT presents them
    exp_t cur_mem;
    bit   have_mem = 1'b0;
    bit   req_seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dm_req === 1'b1) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    have_mem = 1'b0;
                    if (exp_q.size() == 0) chk("unexpected_dm_req", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("kind_at_dm_req", e.kind, K_MEM);
                        if (e.kind == K_MEM) begin cur_mem = e; have_mem = 1'b1; end
                    end
                end
                if (have_mem) begin
                    chk("dm_we", dm_we, cur_mem.we);
                    chk("dm_be", dm_be, cur_mem.be);
                    chk("dm_addr", dm_addr, cur_mem.a);
                    chk("dm_wdata", dm_wdata, cur_mem.d);
                end
            end else begin
                req_seen = 1'b0;
            end
            if (wb_valid === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_wb_valid", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("kind_at_wb_valid", e.kind, K_WB);
                    if (e.kind == K_WB) begin
                        chk("wb_rd", wb_rd, e.rd);
                        chk("wb_data", wb_data, e.d);
                    end
                end
            end
            if (misalign === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_misalign", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("kind_at_misalign", e.kind, K_MIS);
                    if (e.kind == K_MIS) chk("misalign_addr", misalign_addr, e.a);
                end
            end
            if (bus_err === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_bus_err", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("kind_at_bus_err", e.kind, K_ERR);
                end
            end
        end
    end

    task automatic scramble();
        ex_valid      = 1'($urandom);
        ex_load       = 1'($urandom);
        ex_store      = 1'($urandom);
        ex_funct3     = 3'($urandom);
        ex_addr       = $urandom;
        ex_store_data = $urandom;
        ex_rd         = 5'($urandom);
    endtask

    task automatic issue(input bit ld, input bit st, input bit vld, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                         input int delay, input bit noack, input logic [31:0] rdata);
        bit   op, legal, mis, acc;
        int   sz, off, n_acc;
        rsp_t r;
        @(posedge clk); #1;
        ex_valid = vld; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_addr = addr; ex_store_data = sd; ex_rd = rd;
        op    = vld && (ld != st);
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr[1:0]);
        mis   = (off % sz) != 0;
        acc   = op && legal && !mis;
        #1 chk("stall_at_issue", lsu_stall, acc);
        if (op && legal && mis) exp_q.push_back(mk(K_MIS, 1'b0, 4'd0, addr, 32'd0, 5'd0));
        if (acc) begin
            exp_q.push_back(mk(K_MEM, st, m_be(off, sz), {addr[31:2], 2'b00},
                               m_wdata(sd, off), 5'd0));
            r.delay = delay; r.noack = noack; r.rdata = rdata;
            rsp_q.push_back(r);
            if (noack) exp_q.push_back(mk(K_ERR, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0));
            else if (ld) exp_q.push_back(mk(K_WB, 1'b0, 4'd0, 32'd0,
                                            m_load(rdata, off, sz, f3[2]), rd));
            n_acc = noack ? int'(BUS_TO) : delay + 1;
            for (int i = 0; i < n_acc; i++) begin
                @(posedge clk); #1 scramble();
                #1 chk("stall_in_access", lsu_stall, 1'b1);
            end
            @(posedge clk); #1 scramble();
            #1 chk("stall_in_done", lsu_stall, 1'b0);
        end
    endtask

    initial begin
        logic [2:0] lf[5];
        logic [2:0] sf[3];
        lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;
        sf[0] = 3'd0; sf[1] = 3'd1; sf[2] = 3'd2;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_lsu_stall", lsu_stall, 1'b0);
        chk("rst_dm_req", dm_req, 1'b0);
        chk("rst_dm_we", dm_we, 1'b0);
        chk("rst_dm_be", dm_be, 4'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_rd", wb_rd, 5'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_misalign_addr", misalign_addr, 32'd0);
        chk("rst_bus_err", bus_err, 1'b0);
        rst = 1'b0;

        // Directed cases
        issue(1, 0, 1, 3'b010, 32'h0000_0100, 32'h0, 5'd9, 0, 0, 32'hDEAD_BEEF);
        issue(1, 0, 1, 3'b000, 32'h0000_0103, 32'h0, 5'd3, 1, 0, 32'h80FF_0000);
        issue(1, 0, 1, 3'b100, 32'h0000_0103, 32'h0, 5'd4, 2, 0, 32'h80FF_0000);
        issue(0, 1, 1, 3'b000, 32'h0000_0102, 32'h0000_00AB, 5'd0, 0, 0, 32'h0);
        issue(0, 1, 1, 3'b001, 32'h0000_0202, 32'h0000_1234, 5'd0, 3, 0, 32'h0);
        issue(1, 0, 1, 3'b010, 32'h0000_0101, 32'h0, 5'd1, 0, 0, 32'h0);
        issue(1, 0, 1, 3'b010, 32'h0000_0400, 32'h0, 5'd2, 0, 1, 32'h0);
        issue(1, 0, 1, 3'b001, 32'h0000_0402, 32'h0, 5'd0, 3, 0, 32'h8001_1234);
        issue(1, 1, 1, 3'b010, 32'h0000_0500, 32'h0, 5'd5, 0, 0, 32'h0);
        issue(0, 1, 1, 3'b100, 32'h0000_0500, 32'h0, 5'd5, 0, 0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int          k;
            bit          ld, st, vld, na;
            logic [2:0]  f3;
            logic [31:0] a;
            k   = $urandom_range(0, 19);
            ld  = (k < 9) || (k == 18);
            st  = (k >= 9 && k < 18) || (k == 18);
            vld = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else if (ld) f3 = lf[$urandom_range(0, 4)];
            else f3 = sf[$urandom_range(0, 2)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0)
                a[1:0] = a[1:0] & ((f3[1:0] == 2'd0) ? 2'b11 : (f3[1:0] == 2'd1) ? 2'b10 : 2'b00);
            na = ($urandom_range(0, 7) == 0);
            issue(ld, st, vld, f3, a, $urandom, 5'($urandom), $urandom_range(0, 3), na, $urandom);
        end

        // Reset while an access is outstanding
        begin
            rsp_t r;
            @(posedge clk); #1;
            ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
            ex_addr = 32'h0000_0300; ex_store_data = 32'd0; ex_rd = 5'd7;
            exp_q.push_back(mk(K_MEM, 1'b0, 4'b1111, 32'h0000_0300, 32'd0, 5'd0));
            r.delay = 0; r.noack = 1'b1; r.rdata = 32'd0;
            rsp_q.push_back(r);
            #1 chk("stall_rst_issue", lsu_stall, 1'b1);
            @(posedge clk); #1 ex_valid = 1'b0;
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            #1;
            chk("dm_req_after_rst", dm_req, 1'b0);
            chk("wb_valid_after_rst", wb_valid, 1'b0);
            chk("stall_after_rst", lsu_stall, 1'b0);
            repeat (3) @(posedge clk);
            #1 chk("bus_err_after_rst", bus_err, 1'b0);
        end
        issue(1, 0, 1, 3'b101, 32'h0000_0602, 32'h0, 5'd11, 1, 0, 32'hF00D_CAFE);

        repeat (4) @(posedge clk);
        #1;
        chk("expected_events_left", exp_q.size(), 0);
        chk("responses_left", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
